// File: rtl/width_converter_8ton_pkg.sv
`default_nettype none
// ============================================================================
// Module  : width_converter_8ton_pkg
// Brief   : Shared I3C controller constants for the TTI RX byte-to-word path.
// Revision: 1.0 - initial release
// ============================================================================
package width_converter_8ton_pkg;

    localparam int c_tti_rx_data_width = 32;
    localparam int c_rx_word_bytes     = c_tti_rx_data_width / 8;
    localparam int c_rx_bcnt_width     = $clog2(c_rx_word_bytes) + 1;

    typedef logic [c_rx_bcnt_width-1:0] rx_bcnt_t;

endpackage
`default_nettype wire

// File: rtl/width_converter_8ton.sv
`default_nettype none
// ============================================================================
// Module  : width_converter_8ton
// Brief   : Packs RX bytes into Width-bit words for the TTI RX queue.
// Revision: 1.0 - initial release
// ============================================================================
module width_converter_8ton
    import width_converter_8ton_pkg::*;
#(
    parameter int Width = c_tti_rx_data_width
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           sink_valid_i,
    output logic                           sink_ready_o,
    input  logic [7:0]                     sink_data_i,
    input  logic                           sink_flush_i,
    output logic                           source_valid_o,
    input  logic                           source_ready_i,
    output logic [Width-1:0]               source_data_o,
    output logic [$clog2(Width/8):0]       source_bcnt_o,
    output logic                           source_last_o,
    input  logic                           clear_i
);

    localparam int Bytes = Width / 8;
    localparam int CntW  = $clog2(Bytes) + 1;

    if ((Width % 8) != 0 || Width < 16) begin : g_width_check
        $error("width_converter_8ton: Width must be a multiple of 8 and >= 16");
    end

    logic [Width-1:0] acc_q, acc_d, oreg_q, oreg_d;
    logic [CntW-1:0]  acnt_q, acnt_d, obcnt_q, obcnt_d;
    logic             pend_q, pend_d, last_q, last_d;
    logic             ovalid_q, ovalid_d, olast_q, olast_d;
    logic             w_xfer, w_accept;

    assign w_xfer       = pend_q & (~ovalid_q | source_ready_i);
    assign sink_ready_o = ~clear_i & (~pend_q | w_xfer);
    assign w_accept     = sink_valid_i & sink_ready_o;

    always_comb begin
        acc_d    = acc_q;
        acnt_d   = acnt_q;
        pend_d   = pend_q;
        last_d   = last_q;
        oreg_d   = oreg_q;
        obcnt_d  = obcnt_q;
        olast_d  = olast_q;
        ovalid_d = ovalid_q;

        if (w_xfer) begin
            oreg_d   = acc_q;
            obcnt_d  = acnt_q;
            olast_d  = last_q;
            ovalid_d = 1'b1;
            acc_d    = '0;
            acnt_d   = '0;
            pend_d   = 1'b0;
            last_d   = 1'b0;
        end else if (ovalid_q & source_ready_i) begin
            ovalid_d = 1'b0;
        end

        // acnt_d already points at lane 0 when the word left this cycle
        if (w_accept) begin
            for (int i = 0; i < Bytes; i++) begin
                if (acnt_d == CntW'(i)) begin
                    acc_d[8*i +: 8] = sink_data_i;
                end
            end
            acnt_d = acnt_d + 1'b1;
        end

        // A word still waiting for the output register swallows any flush
        if (!pend_d) begin
            if (acnt_d == CntW'(Bytes)) begin
                pend_d = 1'b1;
                last_d = sink_flush_i;
            end else if (sink_flush_i && acnt_d != '0) begin
                pend_d = 1'b1;
                last_d = 1'b1;
            end
        end

        if (clear_i) begin
            acc_d    = '0;
            acnt_d   = '0;
            pend_d   = 1'b0;
            last_d   = 1'b0;
            oreg_d   = '0;
            obcnt_d  = '0;
            olast_d  = 1'b0;
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            acnt_q   <= '0;
            pend_q   <= 1'b0;
            last_q   <= 1'b0;
            oreg_q   <= '0;
            obcnt_q  <= '0;
            olast_q  <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            acnt_q   <= acnt_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            oreg_q   <= oreg_d;
            obcnt_q  <= obcnt_d;
            olast_q  <= olast_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign source_valid_o = ovalid_q;
    assign source_data_o  = oreg_q;
    assign source_bcnt_o  = obcnt_q;
    assign source_last_o  = olast_q;

endmodule
`default_nettype wire

// File: tb/tb_width_converter_8ton.sv
`default_nettype none
// ============================================================================
// Module  : tb_width_converter_8ton
// Brief   : Directed bench with a queue-based word model for width_converter_8ton.
// Revision: 1.0 - initial release
// ============================================================================
module tb_width_converter_8ton;
    import width_converter_8ton_pkg::*;

    localparam int W  = c_tti_rx_data_width;
    localparam int NB = W / 8;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic         sink_valid_i = 1'b0;
    logic [7:0]   sink_data_i = 8'h00;
    logic         sink_flush_i = 1'b0;
    logic         source_ready_i = 1'b0;
    logic         clear_i = 1'b0;
    logic         sink_ready_o;
    logic         source_valid_o;
    logic [W-1:0] source_data_o;
    rx_bcnt_t     source_bcnt_o;
    logic         source_last_o;

    width_converter_8ton #(.Width(W)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sink_valid_i   (sink_valid_i),
        .sink_ready_o   (sink_ready_o),
        .sink_data_i    (sink_data_i),
        .sink_flush_i   (sink_flush_i),
        .source_valid_o (source_valid_o),
        .source_ready_i (source_ready_i),
        .source_data_o  (source_data_o),
        .source_bcnt_o  (source_bcnt_o),
        .source_last_o  (source_last_o),
        .clear_i        (clear_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: bytes held as a queue, one output slot, and a log of words the queue took
    byte unsigned m_acc[$];
    bit           m_pend, m_last, m_ov, m_ol;
    logic [W-1:0] m_od;
    int           m_ob;
    bit           m_xf, m_take;
    logic [W-1:0] got_data[$];
    int           got_bcnt[$];
    bit           got_last[$];

    function automatic bit m_xfer();
        return m_pend && (!m_ov || source_ready_i);
    endfunction

    function automatic bit m_ready();
        return !clear_i && (!m_pend || m_xfer());
    endfunction

    function automatic logic [W-1:0] pack_acc();
        logic [W-1:0] w;
        w = '0;
        foreach (m_acc[k]) w[8*k +: 8] = m_acc[k];
        return w;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_acc.delete();
            m_pend = 0; m_last = 0; m_ov = 0; m_ol = 0; m_od = '0; m_ob = 0;
        end else if (clear_i) begin
            m_acc.delete();
            m_pend = 0; m_last = 0; m_ov = 0; m_ol = 0; m_od = '0; m_ob = 0;
        end else begin
            m_xf   = m_xfer();
            m_take = sink_valid_i && m_ready();
            if (m_ov && source_ready_i) begin
                got_data.push_back(m_od);
                got_bcnt.push_back(m_ob);
                got_last.push_back(m_ol);
            end
            if (m_xf) begin
                m_od = pack_acc(); m_ob = m_acc.size(); m_ol = m_last; m_ov = 1;
                m_acc.delete(); m_pend = 0; m_last = 0;
            end else if (m_ov && source_ready_i) begin
                m_ov = 0;
            end
            if (m_take) m_acc.push_back(sink_data_i);
            if (!m_pend) begin
                if (m_acc.size() == NB) begin
                    m_pend = 1; m_last = sink_flush_i;
                end else if (sink_flush_i && m_acc.size() > 0) begin
                    m_pend = 1; m_last = 1;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            check("rst_sink_ready", sink_ready_o, 1);
            check("rst_valid", source_valid_o, 0);
            check("rst_data", source_data_o, 0);
            check("rst_bcnt", source_bcnt_o, 0);
            check("rst_last", source_last_o, 0);
        end else begin
            check("cyc_sink_ready", sink_ready_o, m_ready());
            check("cyc_valid", source_valid_o, m_ov);
            if (m_ov) begin
                check("cyc_data", source_data_o, m_od);
                check("cyc_bcnt", source_bcnt_o, m_ob);
                check("cyc_last", source_last_o, m_ol);
            end
        end
    end

    logic last_ready;

    task automatic cyc(input bit v, input logic [7:0] d, input bit f, input bit rdy, input bit clr);
        sink_valid_i   = v;
        sink_data_i    = d;
        sink_flush_i   = f;
        source_ready_i = rdy;
        clear_i        = clr;
        #2;
        last_ready = sink_ready_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input bit rdy);
        sink_valid_i   = 0;
        sink_data_i    = 8'h00;
        sink_flush_i   = 0;
        source_ready_i = rdy;
        clear_i        = 0;
    endtask

    int drops;
    logic [W-1:0] exp_words [7];
    int           exp_bcnt  [7];
    bit           exp_last  [7];

    initial begin
        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_sink_ready", sink_ready_o, 1);
        check("reset_valid", source_valid_o, 0);
        check("reset_data", source_data_o, 0);
        rst_ni = 1'b1;
        cyc(0, 8'h00, 0, 1, 0);

        // Four bytes back-to-back: valid exactly one cycle after the last byte
        cyc(1, 8'h11, 0, 1, 0);
        cyc(1, 8'h22, 0, 1, 0);
        cyc(1, 8'h33, 0, 1, 0);
        cyc(1, 8'h44, 0, 1, 0);
        check("w1_not_yet_valid", source_valid_o, 0);
        cyc(0, 8'h00, 0, 0, 0);
        check("w1_valid", source_valid_o, 1);
        check("w1_data", source_data_o, 64'h44332211);
        check("w1_bcnt", source_bcnt_o, 4);
        check("w1_last", source_last_o, 0);
        cyc(0, 8'h00, 0, 1, 0);
        check("w1_drained", source_valid_o, 0);

        // Partial word closed by flush, then a flush on an empty accumulator
        cyc(1, 8'hAA, 0, 0, 0);
        cyc(1, 8'hBB, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        check("flush_data", source_data_o, 64'h0000BBAA);
        check("flush_bcnt", source_bcnt_o, 2);
        check("flush_last", source_last_o, 1);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 1, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        check("empty_flush_no_word", source_valid_o, 0);

        // Twelve bytes at full rate
        drops = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1, 8'(i), 0, 1, 0);
            if (!last_ready) drops++;
        end
        check("stream_no_drops", drops, 0);
        repeat (3) cyc(0, 8'h00, 0, 1, 0);

        // Back-pressure: second word pends and the ninth byte stalls
        drops = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'h10 + 8'(i), 0, 0, 0);
            if (!last_ready) drops++;
        end
        check("bp_first8_accepted", drops, 0);
        cyc(1, 8'h18, 1, 0, 0);
        check("bp_9th_stalled", last_ready, 0);
        check("bp_hold_data", source_data_o, 64'h13121110);
        cyc(1, 8'h18, 0, 0, 0);
        check("bp_9th_stalled2", last_ready, 0);
        check("bp_hold_data2", source_data_o, 64'h13121110);
        check("bp_hold_valid", source_valid_o, 1);
        cyc(1, 8'h18, 0, 1, 0);
        check("bp_9th_on_xfer", last_ready, 1);
        check("bp_word2", source_data_o, 64'h17161514);
        cyc(0, 8'h00, 1, 1, 0);
        repeat (3) cyc(0, 8'h00, 0, 1, 0);

        // Clear with three bytes held and a word in the output register
        for (int i = 0; i < 7; i++) cyc(1, 8'h31 + 8'(i), 0, 0, 0);
        check("clr_pre_valid", source_valid_o, 1);
        cyc(0, 8'h00, 0, 0, 1);
        check("clr_blocks_sink", last_ready, 0);
        idle(0);
        #1;
        check("clr_valid", source_valid_o, 0);
        check("clr_sink_ready", sink_ready_o, 1);
        check("clr_data", source_data_o, 0);
        repeat (4) cyc(0, 8'h00, 0, 1, 0);
        check("clr_no_stale", source_valid_o, 0);

        // Reset pulse mid-word
        cyc(1, 8'h41, 0, 1, 0);
        cyc(1, 8'h42, 0, 1, 0);
        idle(1);
        #2 rst_ni = 1'b0;
        #3;
        check("rstmid_valid", source_valid_o, 0);
        check("rstmid_bcnt", source_bcnt_o, 0);
        check("rstmid_sink_ready", sink_ready_o, 1);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        cyc(0, 8'h00, 1, 1, 0);
        repeat (3) cyc(0, 8'h00, 0, 1, 0);
        check("rstmid_no_stale", source_valid_o, 0);

        // Pin the model's view of every word the queue accepted
        exp_words = '{32'h44332211, 32'h0000BBAA, 32'h04030201, 32'h08070605,
                      32'h0C0B0A09, 32'h13121110, 32'h17161514};
        exp_bcnt  = '{4, 2, 4, 4, 4, 4, 4};
        exp_last  = '{0, 1, 0, 0, 0, 0, 0};
        check("log_count", got_data.size(), 8);
        for (int i = 0; i < 7; i++) begin
            if (i < got_data.size()) begin
                check($sformatf("log_data%0d", i), got_data[i], exp_words[i]);
                check($sformatf("log_bcnt%0d", i), got_bcnt[i], exp_bcnt[i]);
                check($sformatf("log_last%0d", i), got_last[i], exp_last[i]);
            end
        end
        if (got_data.size() == 8) begin
            check("log_data7", got_data[7], 64'h00000018);
            check("log_bcnt7", got_bcnt[7], 1);
            check("log_last7", got_last[7], 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
